// File: rtl/light_bank.sv
// Multi-channel light controller: per-channel switch debounce, one-hot OFF/ON
// state machine in level or toggle mode, programmable auto-off and change strobe.
module light_bank #(
  parameter int CHANNELS  = 4,
  parameter int DEBOUNCE  = 3,
  parameter int TIMEOUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS-1:0]     trigger,
  input  logic [CHANNELS-1:0]     mode,
  input  logic [TIMEOUT_W-1:0]    timeout,
  input  logic                    all_off,
  output logic [CHANNELS-1:0]     light,
  output logic [2*CHANNELS-1:0]   state,
  output logic [CHANNELS-1:0]     changed
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_OFF = 2'b01,
    ST_ON  = 2'b10
  } state_e;

  logic [CHANNELS-1:0]                sw_db_q, sw_db_d;
  logic [CHANNELS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHANNELS-1:0][TIMEOUT_W-1:0] timer_q, timer_d;
  state_e                             state_q [CHANNELS];
  state_e                             state_d [CHANNELS];
  logic [CHANNELS-1:0]                light_q, light_d;
  logic [CHANNELS-1:0]                changed_q, changed_d;
  logic [CHANNELS-1:0]                rise, fall;
  logic [TIMEOUT_W-1:0]               timeout_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_db_q   <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      light_q   <= '0;
      changed_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_OFF;
      end
    end else begin
      sw_db_q   <= sw_db_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      light_q   <= light_d;
      changed_q <= changed_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // A change is accepted only after DEBOUNCE consecutive differing samples.
  always_comb begin
    sw_db_d = sw_db_q;
    cnt_d   = '0;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (trigger[i] != sw_db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_db_d[i] = trigger[i];
          rise[i]    = trigger[i];
          fall[i]    = ~trigger[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Priority: all_off, then debounced event, then auto-off. Timer is zero
  // unless the channel stays ON with no event and auto-off enabled.
  always_comb begin
    timeout_last = timeout - TIMEOUT_W'(1);
    timer_d      = '0;
    light_d      = '0;
    changed_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      if (all_off) begin
        state_d[i] = ST_OFF;
      end else if (rise[i] || fall[i]) begin
        if (!mode[i]) begin
          state_d[i] = rise[i] ? ST_ON : ST_OFF;
        end else if (rise[i]) begin
          state_d[i] = (state_q[i] == ST_ON) ? ST_OFF : ST_ON;
        end
      end else if (state_q[i] == ST_ON && timeout != '0) begin
        if (timer_q[i] >= timeout_last) begin
          state_d[i] = ST_OFF;
        end else begin
          timer_d[i] = timer_q[i] + TIMEOUT_W'(1);
        end
      end
      light_d[i]   = (state_d[i] == ST_ON);
      changed_d[i] = light_d[i] ^ light_q[i];
    end
  end

  always_comb begin
    state = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state[2*i +: 2] = state_q[i];
    end
  end

  assign light   = light_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_light_bank.sv
// Bench for light_bank: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of channels (debounce, mode, auto-off).
module tb_light_bank;

  localparam int CH  = 4;
  localparam int DEB = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  trigger;
  logic [3:0]  mode;
  logic [7:0]  timeout;
  logic        all_off;
  logic [3:0]  light;
  logic [7:0]  state;
  logic [3:0]  changed;

  int tests_run;
  int tests_failed;

  bit m_db  [CH];
  int m_run [CH];
  bit m_on  [CH];
  int m_age [CH];
  bit m_chg [CH];

  light_bank #(.CHANNELS(4), .DEBOUNCE(3), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .mode(mode), .timeout(timeout),
    .all_off(all_off), .light(light), .state(state), .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_db[c] = 0; m_run[c] = 0; m_on[c] = 0; m_age[c] = 0; m_chg[c] = 0;
    end
  endfunction

  // One clock edge of the reference: age counts edges spent ON since entry/event.
  function automatic void model_step();
    for (int c = 0; c < CH; c++) begin
      bit ev;
      bit was;
      ev  = 0;
      was = m_on[c];
      if (trigger[c] != m_db[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          m_db[c]  = trigger[c];
          m_run[c] = 0;
          ev       = 1;
        end
      end else begin
        m_run[c] = 0;
      end
      if (all_off) begin
        m_on[c] = 0; m_age[c] = 0;
      end else if (ev) begin
        if (!mode[c]) m_on[c] = m_db[c];
        else if (m_db[c]) m_on[c] = !m_on[c];
        m_age[c] = 0;
      end else if (m_on[c] && timeout != 0) begin
        if (m_age[c] + 1 >= int'(timeout)) begin
          m_on[c] = 0; m_age[c] = 0;
        end else begin
          m_age[c]++;
        end
      end else begin
        m_age[c] = 0;
      end
      m_chg[c] = (m_on[c] != was);
    end
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [3:0] l;
    logic [3:0] ch;
    logic [7:0] s;
    for (int c = 0; c < CH; c++) begin
      l[c]        = m_on[c];
      ch[c]       = m_chg[c];
      s[2*c +: 2] = m_on[c] ? 2'b10 : 2'b01;
    end
    return {l, s, ch};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; trigger = '0; mode = '0; timeout = '0; all_off = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({light, state, changed} !== 16'h0550) begin
      tests_failed++;
      $display("[TB] FAIL reset: got %h expected %h", {light, state, changed}, 16'h0550);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if ({light, state, changed} !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got %h expected %h", {light, state, changed}, exp_vec());
    end
  endtask

  task automatic test_level();
    logic [3:0] want [4];
    want[0] = 4'b0010; want[1] = 4'b0010; want[2] = 4'b1101; want[3] = 4'b1100;
    trigger[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if ({light[0], state[1:0], changed[0]} !== want[k]) begin
        tests_failed++;
        $display("[TB] FAIL level_ch0 edge%0d: got %b expected %b", k + 1,
                 {light[0], state[1:0], changed[0]}, want[k]);
      end
      tests_run++;
      if ({light, state, changed} !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL level_model: got %h expected %h", {light, state, changed}, exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    trigger[1] = 1'b1;
    repeat (2) tick();
    trigger[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if ({light[1], changed[1]} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL glitch_ch1: got %b expected 00", {light[1], changed[1]});
      end
    end
    trigger[1] = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (light[1] !== 1'b1 || {light, state, changed} !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL glitch_then_hold: got %h expected %h", {light, state, changed}, exp_vec());
    end
  endtask

  task automatic test_toggle();
    mode[2] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      logic after_high;
      trigger[2] = 1'b1;
      repeat (4) tick();
      after_high = light[2];
      tests_run++;
      if (after_high !== ((r % 2) == 0)) begin
        tests_failed++;
        $display("[TB] FAIL toggle_rise%0d: got %b expected %b", r, after_high, (r % 2) == 0);
      end
      trigger[2] = 1'b0;
      repeat (4) tick();
      tests_run++;
      if (light[2] !== ((r % 2) == 0) || {light, state, changed} !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL toggle_fall%0d: got %h expected %h", r, {light, state, changed}, exp_vec());
      end
    end
  endtask

  task automatic test_auto_off();
    timeout = 8'd5;
    all_off = 1'b1;
    tick();
    all_off = 1'b0;
    trigger[0] = 1'b0; repeat (3) tick();
    trigger[0] = 1'b1; repeat (3) tick();
    repeat (4) tick();
    tests_run++;
    if (light[0] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL autooff_early: got %b expected 1", light[0]);
    end
    tick();
    tests_run++;
    if ({light[0], changed[0]} !== 2'b01 || {light, state, changed} !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL autooff_fire: got %h expected %h", {light, state, changed}, exp_vec());
    end
    repeat (8) tick();
    tests_run++;
    if (light[0] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL autooff_stays: got %b expected 0", light[0]);
    end
    trigger[0] = 1'b0; repeat (3) tick();
    trigger[0] = 1'b1; repeat (3) tick();
    tests_run++;
    if (light[0] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL autooff_rearm: got %b expected 1", light[0]);
    end
    // Channel 2 (toggle): fall event lands on the auto-off edge and restarts the count.
    trigger[2] = 1'b1; repeat (3) tick();
    repeat (2) tick();
    trigger[2] = 1'b0; repeat (3) tick();
    tests_run++;
    if (light[2] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL event_beats_autooff: got %b expected 1", light[2]);
    end
    repeat (4) tick();
    tests_run++;
    if (light[2] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL window_restart: got %b expected 1", light[2]);
    end
    tick();
    tests_run++;
    if (light[2] !== 1'b0 || {light, state, changed} !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL window_expire: got %h expected %h", {light, state, changed}, exp_vec());
    end
  endtask

  task automatic test_all_off_simul();
    timeout = 8'd0;
    trigger[3] = 1'b1;
    repeat (2) tick();
    all_off = 1'b1;
    tick();
    all_off = 1'b0;
    tests_run++;
    if (light !== 4'b0000 || {light, state, changed} !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL alloff_vs_rise: got %h expected %h", {light, state, changed}, exp_vec());
    end
    repeat (3) tick();
    tests_run++;
    if (light[3] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL alloff_swdb_kept: got %b expected 0", light[3]);
    end
  endtask

  task automatic test_async_reset();
    timeout = 8'd5;
    trigger[0] = 1'b0; repeat (3) tick();
    trigger[0] = 1'b1; repeat (3) tick();
    repeat (2) tick();
    trigger[3] = 1'b0;
    tick();
    #2 rst = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({light, state, changed} !== 16'h0550) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %h expected %h", {light, state, changed}, 16'h0550);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (light !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL partial_debounce: got %b expected 0000", light);
    end
    tick();
    tests_run++;
    if ({light, state, changed} !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_debounce: got %h expected %h", {light, state, changed}, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(5, 0) == 0) trigger[c] = ~trigger[c];
      end
      if ($urandom_range(49, 0) == 0) mode = 4'($urandom);
      if ($urandom_range(99, 0) == 0) timeout = 8'($urandom_range(7, 0));
      all_off = ($urandom_range(79, 0) == 0);
      tick();
      tests_run++;
      if ({light, state, changed} !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL random n=%0d: got %h expected %h", n, {light, state, changed}, exp_vec());
      end
    end
    all_off = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_level();
    test_glitch();
    test_toggle();
    test_auto_off();
    test_all_off_simul();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
